// File: rtl/key_bank.sv
// key_bank: parametrised key store with valid/ready loading (append or
// indexed), synchronous clear, and a read pointer that cycles through the
// loaded keys on each adv pulse once the bank is locked by kset.
module key_bank #(
  parameter  int unsigned KEY_W     = 8,
  parameter  int unsigned NUM_SLOTS = 4,
  localparam int unsigned IDX_W     = $clog2(NUM_SLOTS),
  localparam int unsigned CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                       dclk,
  input  logic                       reset,
  input  logic                       kset,
  input  logic                       clr,
  input  logic [KEY_W-1:0]           din,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic                       wr_idx_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic                       adv,
  output logic [KEY_W-1:0]           key_out,
  output logic [IDX_W-1:0]           key_idx,
  output logic                       wrap,
  output logic [CNT_W-1:0]           num_keys,
  output logic                       full,
  output logic [KEY_W*NUM_SLOTS-1:0] keys
);

  logic [KEY_W-1:0] slot_q [NUM_SLOTS];
  logic [KEY_W-1:0] slot_d [NUM_SLOTS];
  logic [CNT_W-1:0] num_keys_q, num_keys_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             wrap_q, wrap_d;
  logic             kset_dly_q, kset_dly_d;

  logic             full_w;
  logic             idx_in_range;
  logic             load_acc;
  logic             mode_entry;

  // Handshake and mode-entry detection
  always_comb begin
    full_w       = (num_keys_q == CNT_W'(NUM_SLOTS));
    idx_in_range = (CNT_W'(wr_idx) < CNT_W'(NUM_SLOTS));
    din_ready    = !kset && !clr && (wr_idx_en ? idx_in_range : !full_w);
    load_acc     = din_valid && din_ready;
    mode_entry   = kset && !kset_dly_q;
  end

  // Next-state: clear beats load and advance; load and advance are mutually
  // exclusive because loads need kset=0 and advances need kset=1
  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
    end
    num_keys_d = num_keys_q;
    rd_ptr_d   = rd_ptr_q;
    wrap_d     = 1'b0;
    kset_dly_d = kset;

    if (clr) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slot_d[i] = '0;
      end
      num_keys_d = '0;
      rd_ptr_d   = '0;
    end else begin
      if (load_acc) begin
        if (wr_idx_en) begin
          slot_d[wr_idx] = din;
          // Writing beyond the valid region leaves the count alone (no gap fill)
          if (CNT_W'(wr_idx) == num_keys_q) begin
            num_keys_d = num_keys_q + CNT_W'(1);
          end
        end else begin
          slot_d[num_keys_q[IDX_W-1:0]] = din;
          num_keys_d = num_keys_q + CNT_W'(1);
        end
      end

      if (mode_entry) begin
        rd_ptr_d = '0;
      end else if (kset && adv && (num_keys_q != '0)) begin
        if (CNT_W'(rd_ptr_q) == num_keys_q - CNT_W'(1)) begin
          rd_ptr_d = '0;
          wrap_d   = 1'b1;
        end else begin
          rd_ptr_d = rd_ptr_q + IDX_W'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= '0;
      end
      num_keys_q <= '0;
      rd_ptr_q   <= '0;
      wrap_q     <= 1'b0;
      kset_dly_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
      num_keys_q <= num_keys_d;
      rd_ptr_q   <= rd_ptr_d;
      wrap_q     <= wrap_d;
      kset_dly_q <= kset_dly_d;
    end
  end

  // Output mux of registered state
  always_comb begin
    key_out  = (num_keys_q != '0) ? slot_q[rd_ptr_q] : '0;
    key_idx  = rd_ptr_q;
    wrap     = wrap_q;
    num_keys = num_keys_q;
    full     = full_w;
    keys     = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      keys[i*KEY_W +: KEY_W] = slot_q[i];
    end
  end

endmodule

// File: tb/tb_key_bank.sv
// Self-checking bench for key_bank: directed scenarios followed by random
// traffic, all compared against a behavioural model of the key store.
module tb_key_bank;

  localparam int unsigned KEY_W     = 8;
  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned CNT_W     = 3;

  logic                       dclk = 1'b0;
  logic                       reset;
  logic                       kset;
  logic                       clr;
  logic [KEY_W-1:0]           din;
  logic                       din_valid;
  logic                       din_ready;
  logic                       wr_idx_en;
  logic [IDX_W-1:0]           wr_idx;
  logic                       adv;
  logic [KEY_W-1:0]           key_out;
  logic [IDX_W-1:0]           key_idx;
  logic                       wrap;
  logic [CNT_W-1:0]           num_keys;
  logic                       full;
  logic [KEY_W*NUM_SLOTS-1:0] keys;

  always #5 dclk = ~dclk;

  key_bank #(.KEY_W(KEY_W), .NUM_SLOTS(NUM_SLOTS)) dut (
    .dclk(dclk), .reset(reset), .kset(kset), .clr(clr),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .wr_idx_en(wr_idx_en), .wr_idx(wr_idx), .adv(adv),
    .key_out(key_out), .key_idx(key_idx), .wrap(wrap),
    .num_keys(num_keys), .full(full), .keys(keys)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model of the bank
  int m_slot [NUM_SLOTS];
  int m_cnt;
  int m_ptr;
  int m_wrap;
  int m_kprev;

  logic [7:0] seq_basic [5] = '{8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
  logic       wrap_basic [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] seq_part  [3] = '{8'h5A, 8'hA5, 8'h5A};
  logic       wrap_part [3] = '{1'b0, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NUM_SLOTS; i++) m_slot[i] = 0;
    m_cnt = 0; m_ptr = 0; m_wrap = 0; m_kprev = 0;
  endfunction

  function automatic bit m_ready();
    if (kset || clr) return 1'b0;
    if (wr_idx_en) return int'(wr_idx) < NUM_SLOTS;
    return m_cnt < NUM_SLOTS;
  endfunction

  function automatic void m_edge(input bit rdy);
    m_wrap = 0;
    if (clr) begin
      for (int i = 0; i < NUM_SLOTS; i++) m_slot[i] = 0;
      m_cnt = 0;
      m_ptr = 0;
    end else begin
      if (rdy && din_valid) begin
        if (wr_idx_en) begin
          m_slot[int'(wr_idx)] = int'(din);
          if (int'(wr_idx) == m_cnt) m_cnt++;
        end else begin
          m_slot[m_cnt] = int'(din);
          m_cnt++;
        end
      end
      if (kset && !m_kprev) begin
        m_ptr = 0;
      end else if (kset && adv && m_cnt > 0) begin
        m_ptr = (m_ptr + 1) % m_cnt;
        if (m_ptr == 0) m_wrap = 1;
      end
    end
    m_kprev = int'(kset);
  endfunction

  function automatic logic [63:0] m_keys();
    logic [63:0] k = '0;
    for (int i = 0; i < NUM_SLOTS; i++) k |= 64'(m_slot[i] & 8'hFF) << (8 * i);
    return k;
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".key_out"},  key_out,  (m_cnt > 0) ? 64'(m_slot[m_ptr]) : 64'd0);
    check({tag, ".key_idx"},  key_idx,  64'(m_ptr));
    check({tag, ".wrap"},     wrap,     64'(m_wrap));
    check({tag, ".num_keys"}, num_keys, 64'(m_cnt));
    check({tag, ".full"},     full,     64'(m_cnt == NUM_SLOTS));
    check({tag, ".keys"},     keys,     m_keys());
  endtask

  // One clock cycle: check ready against the model, clock, then check state
  task automatic tick(input string tag);
    bit rdy;
    #1;
    rdy = m_ready();
    check({tag, ".din_ready"}, din_ready, 64'(rdy));
    @(posedge dclk);
    m_edge(rdy);
    #1;
    check_state(tag);
  endtask

  task automatic idle();
    clr = 0; din_valid = 0; wr_idx_en = 0; wr_idx = '0; adv = 0; din = '0;
  endtask

  task automatic append(input logic [7:0] v, input string tag);
    din_valid = 1; wr_idx_en = 0; din = v;
    tick(tag);
    din_valid = 0;
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 reset = 0;
    #1 m_reset();
    check_state(tag);
    #1 reset = 1;
  endtask

  initial begin
    reset = 0; kset = 0;
    idle();
    m_reset();
    repeat (2) @(posedge dclk);
    #1 check_state("reset");
    check("reset.din_ready", din_ready, 64'd1);
    @(negedge dclk) reset = 1;

    // Basic load and cycle
    append(8'h11, "basic.ld"); append(8'h22, "basic.ld");
    append(8'h33, "basic.ld"); append(8'h44, "basic.ld");
    check("basic.num_keys", num_keys, 64'd4);
    check("basic.full", full, 64'd1);
    check("basic.keys", keys, 64'h44332211);
    din_valid = 1; din = 8'h99;
    #1 check("basic.ready_full", din_ready, 64'd0);
    tick("full_reject");
    check("full_reject.keys", keys, 64'h44332211);
    din_valid = 0;
    kset = 1; adv = 1;
    tick("basic.entry");
    check("basic.entry_key", key_out, 64'h11);
    for (int i = 0; i < 5; i++) begin
      tick("basic.adv");
      check("basic.seq_key", key_out, 64'(seq_basic[i]));
      check("basic.seq_wrap", wrap, 64'(wrap_basic[i]));
    end

    // Locked rejection
    adv = 0; din_valid = 1; wr_idx_en = 1; wr_idx = 2'd0; din = 8'hEE;
    #1 check("locked.ready", din_ready, 64'd0);
    tick("locked");
    check("locked.keys", keys, 64'h44332211);
    idle();

    // Partial set
    kset = 0; clr = 1; tick("part.clr"); clr = 0;
    append(8'hA5, "part.ld"); append(8'h5A, "part.ld");
    kset = 1; tick("part.entry");
    check("part.entry_key", key_out, 64'hA5);
    adv = 1;
    for (int i = 0; i < 3; i++) begin
      tick("part.adv");
      check("part.seq_key", key_out, 64'(seq_part[i]));
      check("part.seq_wrap", wrap, 64'(wrap_part[i]));
    end
    adv = 0;

    // Indexed writes, including beyond the valid region
    kset = 0; clr = 1; tick("idx.clr"); clr = 0;
    din_valid = 1; wr_idx_en = 1; wr_idx = 2'd2; din = 8'h77;
    tick("idx.gap");
    check("idx.gap_cnt", num_keys, 64'd0);
    append(8'h01, "idx.ld"); append(8'h02, "idx.ld"); append(8'h03, "idx.ld");
    din_valid = 1; wr_idx_en = 1; wr_idx = 2'd1; din = 8'hFF;
    tick("idx.ow");
    check("idx.ow_keys", keys, 64'h0003FF01);
    check("idx.ow_cnt", num_keys, 64'd3);
    wr_idx = 2'd3; din = 8'h04;
    tick("idx.ext");
    check("idx.ext_cnt", num_keys, 64'd4);
    idle();

    // Clear priority over a simultaneous load
    kset = 0; clr = 1; din_valid = 1; wr_idx_en = 1; wr_idx = 2'd0; din = 8'h5C;
    tick("clr.prio");
    check("clr.keys", keys, 64'd0);
    check("clr.key_out", key_out, 64'd0);
    idle();
    kset = 1; tick("clr.entry");
    adv = 1; tick("clr.adv0"); tick("clr.adv0");
    check("clr.key_idx", key_idx, 64'd0);
    check("clr.wrap", wrap, 64'd0);
    idle();

    // Async reset in use mode at pointer 2
    kset = 0;
    append(8'hC1, "ar.ld"); append(8'hC2, "ar.ld"); append(8'hC3, "ar.ld");
    kset = 1; tick("ar.entry");
    adv = 1; tick("ar.adv"); tick("ar.adv"); adv = 0;
    check("ar.ptr2", key_idx, 64'd2);
    async_reset_pulse("ar.mid");
    check("ar.keys0", keys, 64'd0);
    kset = 0;
    #1 check("ar.ready_after", din_ready, 64'd1);
    tick("ar.post");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) kset = ~kset;
      clr       = ($urandom_range(0, 19) == 0);
      din_valid = 1'($urandom_range(0, 1));
      din       = 8'($urandom);
      wr_idx_en = ($urandom_range(0, 3) == 0);
      wr_idx    = 2'($urandom_range(0, 3));
      adv       = 1'($urandom_range(0, 1));
      tick("rand");
      if ($urandom_range(0, 79) == 0) async_reset_pulse("rand.ar");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
